// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between pipeline memory stage and mem_responder
interface mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ack_o, rdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ack_o, rdata_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder; MEM_RESPONDER_ALIGN_CHECK_EN enables misalignment flagging
module mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic                    we_q;
    logic                    mis_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

    logic                    accept;
    logic                    enter_resp;
    logic                    mis_in;
    logic [DEPTH_LOG2-1:0]   idx_in;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_we;
    logic                    rd_mis;
    logic                    unused_addr;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign mis_in = |bus.addr_i[1:0];
`else
    assign mis_in = 1'b0;
`endif

    assign unused_addr = ^{bus.addr_i[31:DEPTH_LOG2+2], bus.addr_i[1:0]};
    assign idx_in      = bus.addr_i[DEPTH_LOG2+1:2];
    assign accept      = (state == IDLE) && bus.req_i;

    // With LATENCY=1 RESP is entered on the accept edge, so the read uses the live bus
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd0));
    assign rd_idx     = (state == IDLE) ? idx_in     : idx_q;
    assign rd_we      = (state == IDLE) ? bus.we_i   : we_q;
    assign rd_mis     = (state == IDLE) ? mis_in     : mis_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_i) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ack_o   = (state == RESP);
        bus.busy_o  = (state != IDLE);
        bus.rdata_o = rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        bus.err_o   = (state == RESP) && mis_q;
`else
        bus.err_o   = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= bus.we_i;
                mis_q   <= mis_in;
                idx_q   <= idx_in;
                wdata_q <= bus.wdata_i;
                cnt     <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !rd_we) begin
                rdata_q <= rd_mis ? 32'd0 : mem[rd_idx];
            end
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so a pending store never lands
    always_ff @(posedge clk_i) begin
        if ((state == RESP) && we_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int LAT = 2;
    localparam int DL  = 5;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] mdl_mem [0:(1<<DL)-1];
    logic [31:0] mdl_last;
    vec_t        tbl [9];

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(DL)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        bit mis;
        idx = int'(addr[DL+1:2]);
        mis = ALIGN && (addr[1:0] != 2'b00);
        exp_err = mis;
        if (we) begin
            if (!mis) mdl_mem[idx] = wdata;
            exp_rd = mdl_last;
        end else begin
            exp_rd   = mis ? 32'd0 : mdl_mem[idx];
            mdl_last = exp_rd;
        end
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int busy_gaps;
        lat = 0;
        busy_gaps = 0;
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.addr_i  = $urandom;
                bus.wdata_i = $urandom;
            end
            if (bus.ack_o === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy_o !== 1'b1) busy_gaps++;
        end
        check({name, "_latency"}, lat, LAT);
        check({name, "_busy_wait"}, busy_gaps, 0);
        check({name, "_rdata"}, bus.rdata_o, exp_rd);
        check({name, "_err"}, bus.err_o, exp_err);
        bus.req_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_ack_drop"}, bus.ack_o, 1'b0);
        check({name, "_busy_drop"}, bus.busy_o, 1'b0);
        check({name, "_err_idle"}, bus.err_o, 1'b0);
    endtask

    initial begin
        logic [31:0] e_rd;
        logic        e_err;
        logic        r_we;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;

        bus.req_i = 0;  bus.we_i = 0;  bus.addr_i = 0;  bus.wdata_i = 0;
        bus1.req_i = 0; bus1.we_i = 0; bus1.addr_i = 0; bus1.wdata_i = 0;
        mdl_last = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.ack_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_err", bus.err_o, 1'b0);
        check("rst_busy_lat1", bus1.busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < (1 << DL); i++) begin
            model(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), e_rd, e_err);
            txn("init", 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), e_rd, e_err);
        end

        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_0084, 32'h0,         32'h1111_1111, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0020, 32'h0,         32'hA000_0008, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0022, 32'hCAFE_F00D, 32'hA000_0008, ALIGN};
        tbl[6] = '{1'b0, 32'h0000_0020, 32'h0,         ALIGN ? 32'hA000_0008 : 32'hCAFE_F00D, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0023, 32'h0,         ALIGN ? 32'h0000_0000 : 32'hCAFE_F00D, ALIGN};
        tbl[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA000_001F, 1'b0};

        for (int i = 0; i < 9; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
            model(tbl[i].we, tbl[i].addr, tbl[i].wdata, e_rd, e_err);
        end

        // Reset while a store of 0x5 to 0x20 is waiting
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.wdata_i = 32'h5;
        @(posedge clk);
        #1;
        check("midrst_busy_wait", bus.busy_o, 1'b1);
        rst = 1'b0;
        bus.req_i = 1'b0;
        #1;
        check("midrst_ack_async", bus.ack_o, 1'b0);
        check("midrst_busy_async", bus.busy_o, 1'b0);
        check("midrst_rdata_async", bus.rdata_o, 32'd0);
        mdl_last = 32'd0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("midrst_ack_held", bus.ack_o, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        model(1'b0, 32'h20, 32'h0, e_rd, e_err);
        txn("midrst_load", 1'b0, 32'h20, 32'h0, e_rd, e_err);

        // LATENCY=1: one store then four held-request loads, ack every other edge
        @(negedge clk);
        bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.addr_i = 32'h8; bus1.wdata_i = 32'h1234_5678;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus1.we_i = 1'b0;
            check("b2b_ack", bus1.ack_o, 32'(k % 2));
            check("b2b_busy", bus1.busy_o, 32'(k % 2));
            if ((k % 2 == 1) && (k > 1)) check("b2b_rdata", bus1.rdata_o, 32'h1234_5678);
        end
        bus1.req_i = 1'b0;

        for (int i = 0; i < 150; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = $urandom;
            r_wdata = $urandom;
            model(r_we, r_addr, r_wdata, e_rd, e_err);
            txn("rand", r_we, r_addr, r_wdata, e_rd, e_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning request-accept to ack_o cycles (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 5, meaning log2 of the number of 32-bit storage words.
REQ-003 The block SHALL have port clk_i  input  1  single clock, rising-edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_i  input  1  request valid from the pipeline memory stage, held until ack_o.
REQ-006 The block SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port addr_i  input  32  byte address.
REQ-008 The block SHALL have port wdata_i  input  32  store data.
REQ-009 The block SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have port rdata_o  output  32  load data, valid while ack_o is high for a load.
REQ-011 The block SHALL have port busy_o  output  1  transaction in flight; the pipeline uses it as a stall.
REQ-012 The block SHALL have port err_o  output  1  misaligned-access flag, valid with ack_o.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 In IDLE with req_i=1, the rising edge SHALL accept the request: it captures we_i, addr_i and wdata_i into internal registers, then goes to RESP if LATENCY=1, otherwise to WAIT with the counter loaded to LATENCY-2.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-016 ack_o SHALL be high exactly while in RESP (one cycle); RESP SHALL always return to IDLE on the next edge.
REQ-017 The ack_o high cycle SHALL therefore begin LATENCY edges after the accept edge, counting the accept edge as the first.
REQ-018 busy_o SHALL be high whenever the state is not IDLE.
REQ-019 The storage index SHALL be captured addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored (aliasing, no error).
REQ-020 For a load, rdata_o SHALL be registered from storage on the edge entering RESP and SHALL hold its value until the next load response.
REQ-021 For a store, storage SHALL be written on the edge leaving RESP, and rdata_o SHALL be unchanged.
REQ-022 A load issued immediately after a store to the same word SHALL return the stored data.
REQ-023 Changes to req_i, addr_i or wdata_i after the accept edge SHALL be ignored; there is no abort, and the captured transaction completes.
REQ-024 req_i high in the cycle after RESP SHALL be accepted, giving a back-to-back throughput of one transaction per LATENCY+1 cycles.
REQ-025 req_i sampled in WAIT or RESP SHALL NOT start a new transaction.

Reset
REQ-026 With rst_i=0, the block SHALL immediately force state=IDLE, counter=0, ack_o=0, busy_o=0, err_o=0 and rdata_o=0, independent of clk_i.
REQ-027 A reset mid-transaction SHALL discard the transaction; a pending store SHALL NOT be written, and storage contents SHALL be retained, not cleared.
REQ-028 The first accept after reset release SHALL occur no earlier than the first rising edge with rst_i=1.

Configuration
REQ-029 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined: a captured addr[1:0]!=0 SHALL set err_o=1 during the ack_o cycle; a store SHALL be suppressed and a load SHALL return rdata_o=0; FSM timing is unchanged.
REQ-030 Macro MEM_RESPONDER_ALIGN_CHECK_EN undefined: err_o SHALL be tied to 0 and addr[1:0] SHALL be ignored.

Verification
REQ-031 Reset then idle: rst_i=0 for 3 cycles -> ack_o=0, busy_o=0, rdata_o=0x00000000, err_o=0.
REQ-032 Store-then-load, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each ack_o arrives on the 2nd cycle after accept, and the load returns rdata_o=0xDEADBEEF.
REQ-033 LATENCY=1 back-to-back: req_i held high for 4 loads -> ack_o pulses every 2 cycles and busy_o toggles 1,0,1,0.
REQ-034 Aliasing, DEPTH_LOG2=5: store 0x11111111 to 0x004, then load 0x084 -> rdata_o=0x11111111.
REQ-035 Reset mid-store: accept a store of 0x5 to 0x20, assert rst_i in WAIT, then load 0x20 -> returns the prior contents, not 0x5; ack_o is low during reset.
REQ-036 With MEM_RESPONDER_ALIGN_CHECK_EN: store to 0x22 -> err_o=1 with ack_o and word 0x20 unchanged; without the macro the same store writes word 0x20 and err_o=0.
